bsg_wormhole_cid_stamper: RTL and testbench
===========================================

// Module: bsg_wormhole_cid_stamper
// PURPOSE
//  Per-link stage placed directly upstream of a wormhole concentrator input port.
//  Writes this link's concentrator ID (cid_i) into the cid field of every wormhole header flit.
//  Tracks packet boundaries with a length counter, so body flits pass through unmodified.
//  Registers the forward path in a 2-entry FIFO: 1-cycle latency, zero bubbles.
//  The reverse path (concentrator -> client) is a pure pass-through.
// PARAMETERS
//  flit_width_p  "inv"  flit width in bits
//  len_width_p   "inv"  width of header len field (body flits following header)
//  cid_width_p   "inv"  width of header cid field
//  cord_width_p  "inv"  width of header cord field
//  max_len_p     2**len_width_p-1  max legal len; used only under the option macro
//  link_width_lp derived  `bsg_ready_and_link_sif_width(flit_width_p)
// PORTS
//  clk_i           in   1            clock
//  reset_i         in   1            synchronous, active-high reset
//  cid_i           in   cid_width_p  cid stamped into headers; quasi-static
//  link_i          in   link_width_lp  client side: fwd data/v, client ready_and_rev
//  link_o          out  link_width_lp  client side: rev data/v, stamper ready_and_rev
//  stamped_link_i  in   link_width_lp  concentrator side: rev data/v, concentrator ready_and_rev
//  stamped_link_o  out  link_width_lp  concentrator side: stamped fwd data/v, client ready pass-through
//  err_o           out  1            sticky length error (option macro only; else tied 0)
// BEHAVIOUR
//  Header layout, LSB first: cord[cord_width_p], len[len_width_p], cid[cid_width_p]; remaining bits are payload.
//  Fwd handshake: flit accepted when link_i.v & link_o.ready_and_rev.
//   ready_and_rev = FIFO not full; no combinational path from downstream ready.
//  Fwd output: stamped_link_o.v/data = FIFO head; head is dequeued when stamped_link_i.ready_and_rev=1.
//  Rev path: link_o.data/v = stamped_link_i.data/v; stamped_link_o.ready_and_rev = link_i.ready_and_rev.
//  FSM, 2 states:
//   HEADER: on accept, enqueue the flit with cid field := cid_i and other bits unchanged; cnt := len.
//    len==0 -> stay in HEADER; else -> BODY.
//   BODY: on accept, enqueue the flit unmodified; cnt := cnt-1. Accept with cnt==1 -> HEADER.
//  cid_i is sampled only on header accept; changes mid-packet do not affect the current packet.
//  cnt is len_width_p bits wide. It is never decremented below 1 in BODY, so it cannot wrap.
//  Latency: flit accepted in cycle t is visible on stamped_link_o in cycle t+1.
//  Throughput: sustains 1 flit/cycle while downstream is ready every cycle.
//  Simultaneous enqueue+dequeue with FIFO full: the dequeue happens; no enqueue (ready was 0).
//  Downstream stall: FIFO fills after 2 flits, then ready_and_rev=0 until a dequeue.
//  Reset (any cycle, including mid-packet): FIFO emptied, state=HEADER, cnt=0, err_o=0.
//   stamped_link_o.v=0, link_o.ready_and_rev=0 during reset, =1 in the first cycle after.
//   Any in-flight packet is discarded.
// CONFIGURATION
//  BSG_WORMHOLE_CID_STAMPER_LEN_CHECK_EN defined:
//   Header accepted with len > max_len_p sets err_o (sticky until reset).
//   The packet is still forwarded with its len unchanged.
//   Simulation $error is raised with the cid and len.
//  Not defined: no compare logic; err_o tied 0; max_len_p ignored.
// STRUCTURE
//  Shared header bsg_wormhole_router.vh:
//   concentrator header struct (cid/len/cord) via `declare_bsg_wormhole_concentrator_header_s.
//  Shared header bsg_noc_links.vh: `declare_bsg_ready_and_link_sif_s and the width macro.
//  FSM state enum {eHeader, eBody}: local to this module.
//  Sub-module: bsg_two_fifo (width flit_width_p) for the forward buffer.
//   Stamping mux and FSM sit on its input side.
// TESTING
//  Config for all cases: flit=32, len=4, cid=2, cord=5.
//  1. cid_i=2; header len=3 (cid field=0), 3 bodies; downstream always ready:
//     -> header on output 1 cycle later with cid=2; bodies bit-identical; 4 back-to-back flits, no bubble.
//  2. Packet len=0, then packet len=1, back-to-back:
//     -> both headers stamped; FSM returns to HEADER after the single-flit packet.
//  3. Downstream ready=0 for 5 cycles, client v=1:
//     -> exactly 2 flits accepted, then ready_and_rev=0.
//     -> on release, flits come out in order with none lost or duplicated.
//  4. cid_i toggles 1->3 while BODY:
//     -> current bodies unchanged; next header carries cid=3.
//  5. Reset asserted after 2 of 5 flits of a packet:
//     -> v=0 next cycle; next accepted flit is treated as a header and stamped.
//  6. With LEN_CHECK_EN and max_len_p=8: header len=9
//     -> err_o=1 from the next cycle until reset; packet still forwarded.
//     Without the macro: err_o stays 0.

Source files
------------

// File: rtl/bsg_wormhole_cid_stamper_pkg.sv
// Shared types and helpers for the wormhole concentrator-ID stamper.
//   stamper_state_e                  : packet-boundary tracking state
//   bsg_ready_and_link_sif_width()   : width of a ready/valid link bundle
//                                      {v, data[flit], ready_and_rev}
package bsg_wormhole_cid_stamper_pkg;

  typedef enum logic {
    eHeader,
    eBody
  } stamper_state_e;

  function automatic int unsigned bsg_ready_and_link_sif_width(input int unsigned flit_width);
    return flit_width + 2;
  endfunction

endpackage

// File: rtl/bsg_wormhole_cid_stamper_two_fifo.sv
// bsg_two_fifo: two-entry ready/valid FIFO giving a registered forward path
// with full throughput.
//   clk_i, reset_i : clock, synchronous active-high reset
//   data_i, v_i    : enqueue side; accepted when v_i & ready_o
//   ready_o        : not full (held low while in reset)
//   data_o, v_o    : head of queue (v_o held low while in reset)
//   yumi_i         : consumer takes the head this cycle
module bsg_two_fifo #(
  parameter int unsigned width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_r [2];
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic [1:0]         count_r;
  logic               enq;
  logic               deq;

  // Gating with reset keeps both handshakes idle during the reset cycle,
  // even before the first reset edge has cleared the occupancy count.
  assign ready_o = (count_r != 2'd2) & ~reset_i;
  assign v_o     = (count_r != 2'd0) & ~reset_i;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_r[rd_ptr_r];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= ~wr_ptr_r;
      if (deq) rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_r + {1'b0, enq} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_wormhole_cid_stamper.sv
// bsg_wormhole_cid_stamper: writes this link's concentrator ID into the cid
// field of every wormhole header flit, passing body flits unchanged, through
// a 2-entry forward buffer (1-cycle latency, no bubbles). Reverse path is a
// pure pass-through.
// Header layout (LSB first): cord, len, cid, payload.
// Link bundles are {v, data[flit_width_p], ready_and_rev}.
//   clk_i, reset_i  : clock, synchronous active-high reset
//   cid_i           : ID stamped into headers (sampled on header accept)
//   link_i          : client side in  (fwd data/v, client ready)
//   link_o          : client side out (rev data/v, stamper ready)
//   stamped_link_i  : concentrator side in  (rev data/v, concentrator ready)
//   stamped_link_o  : concentrator side out (stamped fwd data/v, client ready)
//   err_o           : sticky header-len error
// Option macro BSG_WORMHOLE_CID_STAMPER_LEN_CHECK_EN enables the len > max_len_p
// check; without it err_o is tied low.
module bsg_wormhole_cid_stamper
  import bsg_wormhole_cid_stamper_pkg::*;
#(
  parameter  int unsigned flit_width_p  = 32,
  parameter  int unsigned len_width_p   = 4,
  parameter  int unsigned cid_width_p   = 2,
  parameter  int unsigned cord_width_p  = 5,
  parameter  int unsigned max_len_p     = (1 << len_width_p) - 1,
  localparam int unsigned link_width_lp = bsg_ready_and_link_sif_width(flit_width_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [cid_width_p-1:0]   cid_i,
  input  logic [link_width_lp-1:0] link_i,
  output logic [link_width_lp-1:0] link_o,
  input  logic [link_width_lp-1:0] stamped_link_i,
  output logic [link_width_lp-1:0] stamped_link_o,
  output logic                     err_o
);

  localparam int unsigned len_lsb_lp = cord_width_p;
  localparam int unsigned cid_lsb_lp = cord_width_p + len_width_p;

  logic                    client_v;
  logic [flit_width_p-1:0] client_data;
  logic                    client_ready;
  logic                    conc_v;
  logic [flit_width_p-1:0] conc_data;
  logic                    conc_ready;

  logic                    stamper_ready;
  logic                    fifo_v;
  logic [flit_width_p-1:0] fifo_data;
  logic [flit_width_p-1:0] stamped_data;
  logic                    accept;
  logic [len_width_p-1:0]  hdr_len;

  stamper_state_e          state_r, state_n;
  logic [len_width_p-1:0]  cnt_r, cnt_n;

  assign {client_v, client_data, client_ready} = link_i;
  assign {conc_v, conc_data, conc_ready}       = stamped_link_i;

  assign link_o         = {conc_v, conc_data, stamper_ready};
  assign stamped_link_o = {fifo_v, fifo_data, client_ready};

  assign accept  = client_v & stamper_ready;
  assign hdr_len = client_data[len_lsb_lp +: len_width_p];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eHeader;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    if (accept) begin
      unique case (state_r)
        eHeader: begin
          cnt_n   = hdr_len;
          state_n = (hdr_len == '0) ? eHeader : eBody;
        end
        eBody: begin
          cnt_n = cnt_r - {{(len_width_p-1){1'b0}}, 1'b1};
          if (cnt_r == {{(len_width_p-1){1'b0}}, 1'b1}) state_n = eHeader;
        end
        default: begin
          state_n = eHeader;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stamped_data = client_data;
    if (state_r == eHeader) stamped_data[cid_lsb_lp +: cid_width_p] = cid_i;
  end

  bsg_two_fifo #(
    .width_p(flit_width_p)
  ) fwd_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i (stamped_data),
    .v_i    (client_v),
    .ready_o(stamper_ready),
    .data_o (fifo_data),
    .v_o    (fifo_v),
    .yumi_i (conc_ready)
  );

`ifdef BSG_WORMHOLE_CID_STAMPER_LEN_CHECK_EN
  localparam logic [len_width_p:0] max_len_lp = max_len_p[len_width_p:0];

  logic err_r;
  logic len_over;

  assign len_over = accept & (state_r == eHeader) & ({1'b0, hdr_len} > max_len_lp);
  assign err_o    = err_r;

  always_ff @(posedge clk_i) begin
    if (reset_i)       err_r <= 1'b0;
    else if (len_over) err_r <= 1'b1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && len_over)
      $error("bsg_wormhole_cid_stamper: header len %0d exceeds max (cid=%0d)", hdr_len, cid_i);
  end
`endif
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_wormhole_cid_stamper.sv
module tb_bsg_wormhole_cid_stamper;

  localparam int FW      = 32;
  localparam int LW      = 4;
  localparam int CW      = 2;
  localparam int CDW     = 5;
  localparam int LINKW   = FW + 2;
  localparam int LEN_LSB = CDW;
  localparam int CID_LSB = CDW + LW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_i;
  logic [CW-1:0]    cid_i;
  logic [LINKW-1:0] link_i, link_o, stamped_link_i, stamped_link_o;
  logic             err_o;

  logic          in_v, cl_ready, rev_v, ds_ready;
  logic [FW-1:0] in_data, rev_data;

  assign link_i         = {in_v, in_data, cl_ready};
  assign stamped_link_i = {rev_v, rev_data, ds_ready};

  bsg_wormhole_cid_stamper #(
    .flit_width_p(FW),
    .len_width_p (LW),
    .cid_width_p (CW),
    .cord_width_p(CDW),
    .max_len_p   (8)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .cid_i         (cid_i),
    .link_i        (link_i),
    .link_o        (link_o),
    .stamped_link_i(stamped_link_i),
    .stamped_link_o(stamped_link_o),
    .err_o         (err_o)
  );

  typedef struct {
    logic [FW-1:0] data;
    bit            is_hdr;
    logic [CW-1:0] cid;
  } src_t;

  typedef struct {
    logic [FW-1:0] data;
    int            cyc;
  } exp_t;

  src_t src_q[$];
  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   n_acc  = 0;
  bit   lat_chk = 0;

`ifdef BSG_WORMHOLE_CID_STAMPER_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  // Reference rule: a header leaves with its cid field replaced by the cid
  // presented at its acceptance; everything else is forwarded as-is.
  function automatic logic [FW-1:0] stamp(input logic [FW-1:0] d, input logic [CW-1:0] c);
    logic [FW-1:0] r;
    r = d;
    r[CID_LSB +: CW] = c;
    return r;
  endfunction

  task automatic add_packet(input int len, input logic [CW-1:0] c);
    logic [FW-1:0] h;
    logic [LW-1:0] l;
    logic [CW-1:0] other;
    src_t          s;
    h = $urandom;
    l = LW'(len);
    h[LEN_LSB +: LW] = l;
    other = c ^ CW'($urandom_range(1, 3));
    h[CID_LSB +: CW] = other;
    s.data = h; s.is_hdr = 1'b1; s.cid = c;
    src_q.push_back(s);
    for (int i = 0; i < len; i++) begin
      s.data = $urandom; s.is_hdr = 1'b0; s.cid = c;
      src_q.push_back(s);
    end
  endtask

  // One cycle: drive at the falling edge, observe 1 time unit later.
  // ds_mode: 0 always ready, 1 random, 2 stalled.
  task automatic step(input bit rand_v, input int ds_mode);
    exp_t e;
    src_t s;
    @(negedge clk);
    if (src_q.size() > 0 && (!rand_v || $urandom_range(0, 3) != 0)) begin
      in_v = 1'b1; in_data = src_q[0].data; cid_i = src_q[0].cid;
    end else begin
      in_v = 1'b0; in_data = $urandom;
    end
    ds_ready = (ds_mode == 0) ? 1'b1 : (ds_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    rev_v    = 1'($urandom);
    rev_data = $urandom;
    cl_ready = 1'($urandom);
    #1;
    total++;
    if (link_o[LINKW-1:1] !== {rev_v, rev_data} || stamped_link_o[0] !== cl_ready)
      $display("FAIL rev_passthru: got rev=%h ready=%b, want rev=%h ready=%b",
               link_o[LINKW-1:1], stamped_link_o[0], {rev_v, rev_data}, cl_ready);
    else passed++;
    if (stamped_link_o[LINKW-1] === 1'b1 && ds_ready) begin
      total++;
      if (exp_q.size() == 0)
        $display("FAIL unexpected_flit: got %h, want no valid flit", stamped_link_o[LINKW-2:1]);
      else begin
        e = exp_q.pop_front();
        if (stamped_link_o[LINKW-2:1] !== e.data)
          $display("FAIL fwd_data: got %h, want %h", stamped_link_o[LINKW-2:1], e.data);
        else if (lat_chk && cyc != e.cyc + 1)
          $display("FAIL latency: out at cycle %0d, want %0d", cyc, e.cyc + 1);
        else passed++;
      end
    end
    if (in_v && link_o[0] === 1'b1) begin
      s = src_q.pop_front();
      e.data = s.is_hdr ? stamp(s.data, s.cid) : s.data;
      e.cyc  = cyc;
      exp_q.push_back(e);
      n_acc++;
    end
    cyc++;
  endtask

  task automatic drain(input bit rand_v, input int ds_mode, input int budget, output int steps);
    steps = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && steps < budget) begin
      step(rand_v, ds_mode);
      steps++;
    end
    total++;
    if (src_q.size() > 0 || exp_q.size() > 0)
      $display("FAIL drain_timeout: got %0d src / %0d outstanding left, want 0/0",
               src_q.size(), exp_q.size());
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1; in_v = 1'b0; ds_ready = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    src_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    @(negedge clk); #1;
    total++;
    if (stamped_link_o[LINKW-1] !== 1'b0 || link_o[0] !== 1'b0 || err_o !== 1'b0)
      $display("FAIL reset_state: got v=%b ready=%b err=%b, want 0 0 0",
               stamped_link_o[LINKW-1], link_o[0], err_o);
    else passed++;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    total++;
    if (stamped_link_o[LINKW-1] !== 1'b0 || link_o[0] !== 1'b1)
      $display("FAIL post_reset: got v=%b ready=%b, want 0 1", stamped_link_o[LINKW-1], link_o[0]);
    else passed++;
  endtask

  task automatic test_basic_packet();
    int st;
    src_t s;
    lat_chk = 1;
    add_packet(3, 2'd2);
    s = src_q[0];
    s.data[CID_LSB +: CW] = '0;
    src_q[0] = s;
    drain(0, 0, 50, st);
    total++;
    if (st != 5) $display("FAIL no_bubble: took %0d cycles, want 5", st);
    else passed++;
  endtask

  task automatic test_short_packets();
    int st;
    lat_chk = 1;
    add_packet(0, 2'd1);
    add_packet(1, 2'd2);
    add_packet(2, 2'd3);
    drain(0, 0, 50, st);
    total++;
    if (st != 7) $display("FAIL short_pkts_cycles: took %0d, want 7", st);
    else passed++;
  endtask

  task automatic test_stall();
    int st;
    lat_chk = 0;
    add_packet(6, 2'd0);
    n_acc = 0;
    for (int i = 0; i < 5; i++) step(0, 2);
    total++;
    if (n_acc != 2) $display("FAIL stall_accepts: got %0d, want 2", n_acc);
    else passed++;
    total++;
    if (link_o[0] !== 1'b0) $display("FAIL stall_ready: got %b, want 0", link_o[0]);
    else passed++;
    drain(0, 0, 50, st);
  endtask

  task automatic test_cid_change();
    int st;
    src_t s;
    lat_chk = 1;
    add_packet(3, 2'd1);
    for (int i = 2; i < 4; i++) begin
      s = src_q[i];
      s.cid = 2'd3;
      src_q[i] = s;
    end
    add_packet(2, 2'd3);
    drain(0, 0, 50, st);
  endtask

  task automatic test_reset_mid_packet();
    int st;
    lat_chk = 0;
    add_packet(4, 2'd2);
    step(0, 0);
    step(0, 0);
    @(negedge clk);
    reset_i = 1'b1; in_v = 1'b1; ds_ready = 1'b1;
    #1;
    total++;
    if (stamped_link_o[LINKW-1] !== 1'b0 || link_o[0] !== 1'b0)
      $display("FAIL midreset_during: got v=%b ready=%b, want 0 0", stamped_link_o[LINKW-1], link_o[0]);
    else passed++;
    @(negedge clk);
    reset_i = 1'b0; in_v = 1'b0;
    #1;
    total++;
    if (stamped_link_o[LINKW-1] !== 1'b0 || link_o[0] !== 1'b1)
      $display("FAIL midreset_after: got v=%b ready=%b, want 0 1", stamped_link_o[LINKW-1], link_o[0]);
    else passed++;
    src_q.delete();
    exp_q.delete();
    lat_chk = 1;
    add_packet(2, 2'd1);
    drain(0, 0, 50, st);
  endtask

  task automatic test_random();
    int st;
    lat_chk = 0;
    for (int p = 0; p < 20; p++) add_packet($urandom_range(0, 8), CW'($urandom));
    drain(1, 1, 3000, st);
    total++;
    if (err_o !== 1'b0) $display("FAIL random_err: got %b, want 0", err_o);
    else passed++;
  endtask

  task automatic test_len_check();
    int st;
    do_reset();
    lat_chk = 0;
    add_packet(9, 2'd2);
    drain(0, 0, 50, st);
    total++;
    if (err_o !== LEN_CHECK) $display("FAIL len_err: got %b, want %b", err_o, LEN_CHECK);
    else passed++;
    add_packet(2, 2'd1);
    drain(0, 1, 100, st);
    total++;
    if (err_o !== LEN_CHECK) $display("FAIL len_err_sticky: got %b, want %b", err_o, LEN_CHECK);
    else passed++;
    do_reset();
    #1;
    total++;
    if (err_o !== 1'b0) $display("FAIL len_err_cleared: got %b, want 0", err_o);
    else passed++;
  endtask

  initial begin
    reset_i = 1'b1; cid_i = '0; in_v = 1'b0; in_data = '0;
    cl_ready = 1'b0; rev_v = 1'b0; rev_data = '0; ds_ready = 1'b1;
    test_reset();
    test_basic_packet();
    test_short_packets();
    test_stall();
    test_cid_change();
    test_reset_mid_packet();
    test_random();
    test_len_check();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
